// File: rtl/mips_cpu_pkg.sv
// ---- mips_cpu_pkg : state, opcode/function codes and control encodings (rev 1.0) ----
// Shared by the multicycle control sequencer and its instruction classifier.
`default_nettype none

package mips_cpu_pkg;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXEC    = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4,
    MD_WAIT = 3'd5,
    HALT    = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    CL_UNDEF, CL_ALU_R, CL_SHIFT, CL_ALU_IMM_S, CL_ALU_IMM_Z,
    CL_LOAD, CL_STORE, CL_BRANCH, CL_J, CL_JAL, CL_JR, CL_JALR,
    CL_MD, CL_MFHILO
  } instr_class_t;

  typedef enum logic [2:0] {
    BR_EQ, BR_NE, BR_LEZ, BR_GTZ, BR_LTZ, BR_GEZ
  } br_cond_t;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LWL    = 6'h22;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_LWR    = 6'h26;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SWL    = 6'h2A;
  localparam logic [5:0] OP_SW     = 6'h2B;
  localparam logic [5:0] OP_SWR    = 6'h2E;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_JALR  = 6'h09;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  localparam logic [4:0] RT_BLTZ = 5'd0;
  localparam logic [4:0] RT_BGEZ = 5'd1;

  localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_REG    = 2'd3;

  localparam logic [1:0] ALUB_RT    = 2'd0;
  localparam logic [1:0] ALUB_SIMM  = 2'd1;
  localparam logic [1:0] ALUB_ZIMM  = 2'd2;
  localparam logic [1:0] ALUB_SHAMT = 2'd3;

  localparam logic [1:0] REGDST_RT  = 2'd0;
  localparam logic [1:0] REGDST_RD  = 2'd1;
  localparam logic [1:0] REGDST_R31 = 2'd2;

  function automatic logic [1:0] alu_src_b_for(instr_class_t c);
    case (c)
      CL_SHIFT:                          return ALUB_SHAMT;
      CL_ALU_IMM_S, CL_LOAD, CL_STORE:   return ALUB_SIMM;
      CL_ALU_IMM_Z:                      return ALUB_ZIMM;
      default:                           return ALUB_RT;
    endcase
  endfunction

  // Flags come from the ALU computing rs-rt (BEQ/BNE) or rs-0 (sign tests).
  function automatic logic branch_taken(br_cond_t c, logic zero, logic neg);
    case (c)
      BR_EQ:   return zero;
      BR_NE:   return !zero;
      BR_LEZ:  return zero || neg;
      BR_GTZ:  return !zero && !neg;
      BR_LTZ:  return neg;
      BR_GEZ:  return !neg;
      default: return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mips_cpu_ctrl_decode.sv
// ---- mips_cpu_ctrl_decode : op/func/rt -> instruction class (rev 1.0) ----
// Mult/div functions are recognised only when MIPS_CPU_MULTDIV_EN is defined.
`default_nettype none

module mips_cpu_ctrl_decode
  import mips_cpu_pkg::*;
(
  input  logic [5:0]   op,
  input  logic [5:0]   func,
  input  logic [4:0]   rt,
  output instr_class_t cls,
  output br_cond_t     br_cond
);

  always_comb begin
    cls     = CL_UNDEF;
    br_cond = BR_EQ;
    case (op)
      OP_RTYPE: begin
        case (func)
          F_SLL, F_SRL, F_SRA:                      cls = CL_SHIFT;
          F_SLLV, F_SRLV, F_SRAV,
          F_ADD, F_ADDU, F_SUB, F_SUBU,
          F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: cls = CL_ALU_R;
          F_JR:                                     cls = CL_JR;
          F_JALR:                                   cls = CL_JALR;
`ifdef MIPS_CPU_MULTDIV_EN
          F_MULT, F_MULTU, F_DIV, F_DIVU:           cls = CL_MD;
          F_MFHI, F_MFLO:                           cls = CL_MFHILO;
`endif
          default:                                  cls = CL_UNDEF;
        endcase
      end
      OP_REGIMM: begin
        if (rt == RT_BLTZ) begin
          cls     = CL_BRANCH;
          br_cond = BR_LTZ;
        end else if (rt == RT_BGEZ) begin
          cls     = CL_BRANCH;
          br_cond = BR_GEZ;
        end
      end
      OP_J:    cls = CL_J;
      OP_JAL:  cls = CL_JAL;
      OP_BEQ:  begin cls = CL_BRANCH; br_cond = BR_EQ;  end
      OP_BNE:  begin cls = CL_BRANCH; br_cond = BR_NE;  end
      OP_BLEZ: begin cls = CL_BRANCH; br_cond = BR_LEZ; end
      OP_BGTZ: begin cls = CL_BRANCH; br_cond = BR_GTZ; end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU:     cls = CL_ALU_IMM_S;
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI:         cls = CL_ALU_IMM_Z;
      OP_LB, OP_LH, OP_LWL, OP_LW,
      OP_LBU, OP_LHU, OP_LWR:                   cls = CL_LOAD;
      OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR:      cls = CL_STORE;
      default:                                  cls = CL_UNDEF;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mips_cpu_ctrl_fsm.sv
// ---- mips_cpu_ctrl_fsm : multicycle FETCH/DECODE/EXEC/MEM/WB sequencer (rev 1.0) ----
// Define MIPS_CPU_MULTDIV_EN to enable the md_start/md_done mult/div handshake.
`default_nettype none

module mips_cpu_ctrl_fsm
  import mips_cpu_pkg::*;
#(
  parameter bit RESET_VECTOR_ZERO_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic [4:0] rt,
  input  logic       pc_is_zero,
  input  logic       alu_zero,
  input  logic       alu_neg,
  input  logic       waitrequest,
  input  logic       md_done,
  output logic       ir_write,
  output logic       ir_sel,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_addr_sel,
  output logic [1:0] alu_src_b,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic       md_start,
  output logic       active,
  output logic [2:0] state
);

  state_t       cur_state, next_state;
  instr_class_t dec_cls, cls_q;
  br_cond_t     dec_br, br_q;
  logic         fetch_halt;
  logic         br_taken;

  mips_cpu_ctrl_decode u_decode (
    .op      (op),
    .func    (func),
    .rt      (rt),
    .cls     (dec_cls),
    .br_cond (dec_br)
  );

`ifndef MIPS_CPU_MULTDIV_EN
  logic unused_md_done;
  assign unused_md_done = md_done;
`endif

  assign fetch_halt = RESET_VECTOR_ZERO_HALT && pc_is_zero;
  assign br_taken   = branch_taken(br_q, alu_zero, alu_neg);
  assign active     = (cur_state != HALT);
  assign state      = cur_state;

  // The IR is stable from DECODE onward, so the class is captured once there.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= FETCH;
      cls_q     <= CL_UNDEF;
      br_q      <= BR_EQ;
    end else begin
      cur_state <= next_state;
      if (cur_state == DECODE) begin
        cls_q <= dec_cls;
        br_q  <= dec_br;
      end
    end
  end

  always_comb begin
    next_state = cur_state;
    case (cur_state)
      FETCH: begin
        if (fetch_halt)        next_state = HALT;
        else if (!waitrequest) next_state = DECODE;
      end
      DECODE: next_state = EXEC;
      EXEC: begin
        case (cls_q)
          CL_BRANCH, CL_J, CL_JAL, CL_JR, CL_JALR:               next_state = FETCH;
          CL_LOAD, CL_STORE:                                     next_state = MEM;
          CL_ALU_R, CL_SHIFT, CL_ALU_IMM_S, CL_ALU_IMM_Z,
          CL_MFHILO:                                             next_state = WB;
`ifdef MIPS_CPU_MULTDIV_EN
          CL_MD:                                                 next_state = MD_WAIT;
`endif
          default:                                               next_state = HALT;
        endcase
      end
      MEM: begin
        if (!waitrequest) next_state = (cls_q == CL_LOAD) ? WB : FETCH;
      end
      WB: next_state = FETCH;
`ifdef MIPS_CPU_MULTDIV_EN
      MD_WAIT: begin
        if (md_done) next_state = FETCH;
      end
`endif
      HALT:    next_state = HALT;
      default: next_state = FETCH;
    endcase
  end

  // Reset forces every strobe low in the same cycle, aborting any transfer.
  always_comb begin
    ir_write     = 1'b0;
    ir_sel       = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_SRC_SEQ;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr_sel = 1'b0;
    alu_src_b    = ALUB_RT;
    reg_write    = 1'b0;
    reg_dst      = REGDST_RT;
    md_start     = 1'b0;
    if (!reset) begin
      case (cur_state)
        FETCH: begin
          if (!fetch_halt) begin
            mem_read = 1'b1;
            if (!waitrequest) begin
              ir_write = 1'b1;
              ir_sel   = 1'b1;
              pc_write = 1'b1;
            end
          end
        end
        EXEC: begin
          alu_src_b = alu_src_b_for(cls_q);
          case (cls_q)
            CL_BRANCH: begin
              pc_write = br_taken;
              pc_src   = PC_SRC_BRANCH;
            end
            CL_J: begin
              pc_write = 1'b1;
              pc_src   = PC_SRC_JUMP;
            end
            CL_JAL: begin
              pc_write  = 1'b1;
              pc_src    = PC_SRC_JUMP;
              reg_write = 1'b1;
              reg_dst   = REGDST_R31;
            end
            CL_JR: begin
              pc_write = 1'b1;
              pc_src   = PC_SRC_REG;
            end
            CL_JALR: begin
              pc_write  = 1'b1;
              pc_src    = PC_SRC_REG;
              reg_write = 1'b1;
              reg_dst   = REGDST_RD;
            end
`ifdef MIPS_CPU_MULTDIV_EN
            CL_MD: md_start = 1'b1;
`endif
            default: ;
          endcase
        end
        MEM: begin
          alu_src_b    = alu_src_b_for(cls_q);
          mem_addr_sel = 1'b1;
          mem_read     = (cls_q == CL_LOAD);
          mem_write    = (cls_q == CL_STORE);
        end
        WB: begin
          alu_src_b = alu_src_b_for(cls_q);
          reg_write = 1'b1;
          reg_dst   = (cls_q == CL_ALU_R || cls_q == CL_SHIFT || cls_q == CL_MFHILO)
                      ? REGDST_RD : REGDST_RT;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mips_cpu_ctrl_fsm.sv
// ---- tb_mips_cpu_ctrl_fsm : directed bench for the multicycle control sequencer (rev 1.0) ----
// Strobe vector order: {ir_write, ir_sel, pc_write, mem_read, mem_write, reg_write, md_start}.
`default_nettype none

module tb_mips_cpu_ctrl_fsm;

  localparam logic [2:0] ST_FETCH = 3'd0, ST_DECODE = 3'd1, ST_EXEC = 3'd2, ST_MEM = 3'd3;
  localparam logic [2:0] ST_WB = 3'd4, ST_MDW = 3'd5, ST_HALT = 3'd6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'h00;
  logic [5:0] func = 6'h21;
  logic [4:0] rt = 5'd0;
  logic       pc_is_zero = 1'b0;
  logic       alu_zero = 1'b0;
  logic       alu_neg = 1'b0;
  logic       waitrequest = 1'b0;
  logic       md_done = 1'b0;
  logic       ir_write, ir_sel, pc_write, mem_read, mem_write, mem_addr_sel;
  logic       reg_write, md_start, active;
  logic [1:0] pc_src, alu_src_b, reg_dst;
  logic [2:0] state;
  logic [6:0] strobes;

  int checks = 0;
  int passed = 0;

  assign strobes = {ir_write, ir_sel, pc_write, mem_read, mem_write, reg_write, md_start};

  always #5 clk = ~clk;

  mips_cpu_ctrl_fsm #(.RESET_VECTOR_ZERO_HALT(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .func(func), .rt(rt),
    .pc_is_zero(pc_is_zero), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .waitrequest(waitrequest), .md_done(md_done),
    .ir_write(ir_write), .ir_sel(ir_sel), .pc_write(pc_write), .pc_src(pc_src),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr_sel(mem_addr_sel),
    .alu_src_b(alu_src_b), .reg_write(reg_write), .reg_dst(reg_dst),
    .md_start(md_start), .active(active), .state(state)
  );

  // One cycle: drive inputs just after the falling edge, let them settle.
  task automatic cyc(input logic wr, input logic z, input logic done);
    @(negedge clk);
    waitrequest = wr;
    alu_zero    = z;
    md_done     = done;
    #1;
  endtask

  task automatic do_reset_release();
    @(negedge clk); reset = 1'b1; waitrequest = 1'b0; #1;
    checks++; if (strobes !== 7'b0) $display("FAIL rst_strobes got %b want 0000000", strobes); else passed++;
    @(negedge clk); reset = 1'b0; pc_is_zero = 1'b0; waitrequest = 1'b1; #1;
    checks++; if (state !== ST_FETCH) $display("FAIL rst_state got %0d want %0d", state, ST_FETCH); else passed++;
    checks++; if (active !== 1'b1) $display("FAIL rst_active got %b want 1", active); else passed++;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++; if (strobes !== 7'b0) $display("FAIL reset_strobes got %b want 0000000", strobes); else passed++;
    checks++; if (state !== ST_FETCH) $display("FAIL reset_state got %0d want 0", state); else passed++;
    @(negedge clk); reset = 1'b0; waitrequest = 1'b1; #1;
    checks++; if (active !== 1'b1) $display("FAIL reset_active got %b want 1", active); else passed++;
    checks++; if (strobes !== 7'b0001000) $display("FAIL reset_fetch_read got %b want 0001000", strobes); else passed++;
  endtask

  task automatic test_addu();
    op = 6'h00; func = 6'h21;
    cyc(0, 0, 0);
    checks++; if (strobes !== 7'b1111000) $display("FAIL addu_fetch got %b want 1111000", strobes); else passed++;
    checks++; if ({pc_src, mem_addr_sel} !== 3'b000) $display("FAIL addu_fetch_sel got %b want 000", {pc_src, mem_addr_sel}); else passed++;
    cyc(0, 0, 0);
    checks++; if ({state, strobes} !== {ST_DECODE, 7'b0}) $display("FAIL addu_decode got %0d/%b want 1/0000000", state, strobes); else passed++;
    cyc(0, 0, 0);
    checks++; if ({state, alu_src_b, strobes} !== {ST_EXEC, 2'd0, 7'b0}) $display("FAIL addu_exec got %0d/%0d/%b want 2/0/0000000", state, alu_src_b, strobes); else passed++;
    cyc(0, 0, 0);
    checks++; if ({state, strobes, reg_dst} !== {ST_WB, 7'b0000010, 2'd1}) $display("FAIL addu_wb got %0d/%b/%0d want 4/0000010/1", state, strobes, reg_dst); else passed++;
    cyc(1, 0, 0);
    checks++; if (state !== ST_FETCH) $display("FAIL addu_return got %0d want 0", state); else passed++;
  endtask

  task automatic test_ori();
    op = 6'h0D;
    cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
    checks++; if (alu_src_b !== 2'd2) $display("FAIL ori_alub got %0d want 2", alu_src_b); else passed++;
    cyc(0, 0, 0);
    checks++; if ({state, reg_write, reg_dst} !== {ST_WB, 1'b1, 2'd0}) $display("FAIL ori_wb got %0d/%b/%0d want 4/1/0", state, reg_write, reg_dst); else passed++;
  endtask

  task automatic test_lw_stall();
    op = 6'h23;
    cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
    checks++; if ({state, alu_src_b} !== {ST_EXEC, 2'd1}) $display("FAIL lw_exec got %0d/%0d want 2/1", state, alu_src_b); else passed++;
    for (int i = 0; i < 4; i++) begin
      cyc(i < 3, 0, 0);
      checks++;
      if ({state, strobes, mem_addr_sel} !== {ST_MEM, 7'b0001000, 1'b1})
        $display("FAIL lw_mem%0d got %0d/%b/%b want 3/0001000/1", i, state, strobes, mem_addr_sel);
      else passed++;
    end
    cyc(0, 0, 0);
    checks++; if ({state, strobes, reg_dst} !== {ST_WB, 7'b0000010, 2'd0}) $display("FAIL lw_wb got %0d/%b/%0d want 4/0000010/0", state, strobes, reg_dst); else passed++;
  endtask

  task automatic test_fetch_stall_store();
    op = 6'h2B;
    for (int i = 0; i < 3; i++) begin
      cyc(i < 2, 0, 0);
      checks++;
      if (strobes !== ((i < 2) ? 7'b0001000 : 7'b1111000))
        $display("FAIL fstall_c%0d got %b want %b", i, strobes, (i < 2) ? 7'b0001000 : 7'b1111000);
      else passed++;
    end
    cyc(0, 0, 0); cyc(0, 0, 0);
    cyc(0, 0, 0);
    checks++; if ({state, strobes, mem_addr_sel} !== {ST_MEM, 7'b0000100, 1'b1}) $display("FAIL sw_mem got %0d/%b/%b want 3/0000100/1", state, strobes, mem_addr_sel); else passed++;
    cyc(1, 0, 0);
    checks++; if (state !== ST_FETCH) $display("FAIL sw_return got %0d want 0", state); else passed++;
  endtask

  task automatic test_branch_jump();
    op = 6'h04;
    cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 1, 0);
    checks++; if ({strobes, pc_src} !== {7'b0010000, 2'd1}) $display("FAIL beq_taken got %b/%0d want 0010000/1", strobes, pc_src); else passed++;
    cyc(1, 0, 0);
    checks++; if (state !== ST_FETCH) $display("FAIL beq_taken_ret got %0d want 0", state); else passed++;
    cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
    checks++; if ({state, strobes} !== {ST_EXEC, 7'b0}) $display("FAIL beq_not_taken got %0d/%b want 2/0000000", state, strobes); else passed++;
    cyc(1, 0, 0);
    checks++; if (state !== ST_FETCH) $display("FAIL beq_nt_ret got %0d want 0", state); else passed++;
    op = 6'h03;
    cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
    checks++; if ({strobes, pc_src, reg_dst} !== {7'b0010010, 2'd2, 2'd2}) $display("FAIL jal_exec got %b/%0d/%0d want 0010010/2/2", strobes, pc_src, reg_dst); else passed++;
    cyc(1, 0, 0);
    checks++; if (state !== ST_FETCH) $display("FAIL jal_ret got %0d want 0", state); else passed++;
  endtask

  task automatic test_jr_halt();
    op = 6'h00; func = 6'h08;
    cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
    checks++; if ({strobes, pc_src} !== {7'b0010000, 2'd3}) $display("FAIL jr_exec got %b/%0d want 0010000/3", strobes, pc_src); else passed++;
    @(negedge clk); pc_is_zero = 1'b1; waitrequest = 1'b0; #1;
    checks++; if ({state, strobes} !== {ST_FETCH, 7'b0}) $display("FAIL halt_fetch got %0d/%b want 0/0000000", state, strobes); else passed++;
    cyc(0, 0, 0);
    checks++; if ({state, active, strobes} !== {ST_HALT, 1'b0, 7'b0}) $display("FAIL halt_state got %0d/%b/%b want 6/0/0000000", state, active, strobes); else passed++;
    cyc(0, 0, 0);
    checks++; if (state !== ST_HALT) $display("FAIL halt_sticky got %0d want 6", state); else passed++;
    do_reset_release();
  endtask

  task automatic test_undefined();
    op = 6'h3F;
    cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
    checks++; if (state !== ST_EXEC) $display("FAIL undef_exec got %0d want 2", state); else passed++;
    cyc(0, 0, 0);
    checks++; if ({state, active} !== {ST_HALT, 1'b0}) $display("FAIL undef_halt got %0d/%b want 6/0", state, active); else passed++;
    do_reset_release();
  endtask

  task automatic test_multdiv();
    op = 6'h00; func = 6'h18;
`ifdef MIPS_CPU_MULTDIV_EN
    cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
    checks++; if ({state, strobes} !== {ST_EXEC, 7'b0000001}) $display("FAIL mult_start got %0d/%b want 2/0000001", state, strobes); else passed++;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, i == 4);
      checks++;
      if ({state, strobes} !== {ST_MDW, 7'b0})
        $display("FAIL mult_wait%0d got %0d/%b want 5/0000000", i, state, strobes);
      else passed++;
    end
    cyc(1, 0, 0);
    checks++; if (state !== ST_FETCH) $display("FAIL mult_done got %0d want 0", state); else passed++;
    cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
    checks++; if (state !== ST_MDW) $display("FAIL mult2_wait got %0d want 5", state); else passed++;
    do_reset_release();
`else
    cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 1);
    checks++; if ({state, strobes} !== {ST_EXEC, 7'b0}) $display("FAIL mult_off_exec got %0d/%b want 2/0000000", state, strobes); else passed++;
    cyc(0, 0, 1);
    checks++; if (state !== ST_HALT) $display("FAIL mult_off_halt got %0d want 6", state); else passed++;
    do_reset_release();
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_addu();
    test_ori();
    test_lw_stall();
    test_fetch_stall_store();
    test_branch_jump();
    test_jr_halt();
    test_undefined();
    test_multdiv();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
